axi_regs_arbiter: RTL and testbench
===================================

Name: axi_regs_arbiter

Overview:
- Shares one single-port 32-bit register store between the AXI slave register path and an internal hardware requester (SATA host controller status/command logic).
- The AXI side arrives as BRAM-style strobes from the AXI-to-BRAM bridge and is never stalled mid-burst.
- The hardware side uses a req/ack handshake and is served in idle slots.
- A starvation guard throttles new AXI bursts through the bridge's dev_ready input.

Parameters:
- REGISTERS_CNT, 20, number of 32-bit registers in the store (word-addressed 0..REGISTERS_CNT-1).
- ADDRESS_BITS, 16, width of the word addresses on both sides.
- MAX_WAIT, 4, cycles a pending hw request may wait before AXI is throttled (1..255).

Ports:
- aclk  in  1  clock for all logic
- rst  in  1  asynchronous reset, active-high
- bram_waddr  in  ADDRESS_BITS  AXI write word address
- bram_wdata  in  32  AXI write data
- bram_wstb  in  4  AXI byte strobes
- bram_wen  in  1  AXI write enable, one word per cycle
- bram_raddr  in  ADDRESS_BITS  AXI read word address
- bram_ren  in  1  AXI read enable (store access cycle)
- bram_regen  in  1  AXI read output-register enable
- bram_rdata  out  32  AXI read data
- axi_dev_ready  out  1  to bridge dev_ready; low blocks new AXI bursts
- hw_req  in  1  hw access request, held until hw_ack
- hw_we  in  1  1 = write, 0 = read; stable while hw_req
- hw_addr  in  ADDRESS_BITS  hw word address; stable while hw_req
- hw_wdata  in  32  hw write data
- hw_wstb  in  4  hw byte strobes
- hw_ack  out  1  one-cycle completion pulse
- hw_rdata  out  32  hw read data, valid with hw_ack
- hw_err  out  1  with hw_ack: address out of range
- upd_valid  out  1  one-cycle pulse: a register was written by AXI
- upd_addr  out  ADDRESS_BITS  address of that AXI write

Behaviour:
- Reset (async, rst=1):
  - Outputs: all registers 0, bram_rdata=0, hw_rdata=0, hw_ack=0, hw_err=0, upd_valid=0, upd_addr=0, axi_dev_ready=1.
  - FSM goes to IDLE; wait counter is cleared.
  - A request that is mid-flight at reset is dropped without an ack. The requester re-issues it after reset.
- Store access: exactly one access per cycle. Priority is AXI write, then AXI read, then hw.
  - bram_wen and bram_ren in the same cycle cannot come from the bridge. If they do, the write wins and the read returns the stale internal latch.
- AXI write:
  - On a bram_wen cycle, the byte lanes selected by bram_wstb are updated at the clock edge.
  - upd_valid=1 and upd_addr=bram_waddr on the next cycle.
  - Out-of-range address: the write is dropped and upd_valid stays 0.
- AXI read pipeline:
  - Cycle t (bram_ren): the store word at bram_raddr is latched into an internal register.
  - Cycle t+1 (bram_regen): bram_rdata loads the latch; the data is visible from t+2.
  - bram_rdata holds when bram_regen=0.
  - Out-of-range reads return 32'h0.
- Hw FSM:
  - IDLE:
    - hw_req=1 and no AXI access this cycle: perform the access now and go to ACK.
    - hw_req=1 and an AXI access is present: go to WAIT with the counter at 1.
  - WAIT:
    - On the first cycle with bram_wen=0 and bram_ren=0, perform the access and go to ACK.
    - Otherwise the counter increments, saturating at MAX_WAIT.
  - ACK:
    - hw_ack=1 for one cycle. For reads, hw_rdata holds the word.
    - hw_err=1 if hw_addr >= REGISTERS_CNT; such writes are dropped and such reads return 0.
    - Go to IDLE. hw_req is ignored in ACK, so back-to-back requests cost at least 2 cycles each.
- Starvation guard:
  - axi_dev_ready is registered. It goes low on the cycle after the counter reaches MAX_WAIT and stays low until the cycle after the hw access executes.
  - A burst already in progress completes. The hw access is served in the first gap after that burst.
- Hw write vs a queued AXI write to the same address: strict time order. The later access overwrites the overlapping byte lanes.
- Address width: only addresses < REGISTERS_CNT are valid. Upper address bits are not ignored; any address >= REGISTERS_CNT is out of range.

Test Plan:
- Reset, then AXI write addr 3 = 32'hA5A5_1234 with wstb=4'hF, then AXI read addr 3 -> bram_rdata=32'hA5A5_1234 two cycles after ren; upd_valid pulses with upd_addr=3.
- Hw write addr 5 = 32'h0000_00FF with wstb=4'b0001 while AXI is idle -> hw_ack exactly 1 cycle after req; a subsequent hw read of addr 5 returns 32'h0000_00FF with hw_err=0.
- Hw read request during a continuous 16-beat AXI write burst, MAX_WAIT=4 -> axi_dev_ready falls 5 cycles after the req; the burst finishes; hw_ack arrives 1 cycle after the first idle cycle; axi_dev_ready returns to 1 the cycle after the access.
- Hw write addr 25 with REGISTERS_CNT=20 -> hw_ack with hw_err=1, no register changes; AXI read of addr 25 -> bram_rdata=0.
- AXI wstb=4'b1100 writes 32'hDEAD_0000 over 32'h1111_2222 -> register reads 32'hDEAD_2222.
- Assert rst in WAIT state with hw_req pending -> no hw_ack, axi_dev_ready=1, all registers 0; after release, the held hw_req is served normally.

Source files
------------

// File: rtl/axi_regs_arbiter.sv
// Single-port 32-bit register store shared between the AXI BRAM bridge and an
// internal hw requester; AXI always wins, hw is served in idle slots.
module axi_regs_arbiter #(
    parameter int REGISTERS_CNT = 20,
    parameter int ADDRESS_BITS  = 16,
    parameter int MAX_WAIT      = 4
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic [ADDRESS_BITS-1:0] bram_waddr,
    input  logic [31:0]             bram_wdata,
    input  logic [3:0]              bram_wstb,
    input  logic                    bram_wen,
    input  logic [ADDRESS_BITS-1:0] bram_raddr,
    input  logic                    bram_ren,
    input  logic                    bram_regen,
    output logic [31:0]             bram_rdata,
    output logic                    axi_dev_ready,
    input  logic                    hw_req,
    input  logic                    hw_we,
    input  logic [ADDRESS_BITS-1:0] hw_addr,
    input  logic [31:0]             hw_wdata,
    input  logic [3:0]              hw_wstb,
    output logic                    hw_ack,
    output logic [31:0]             hw_rdata,
    output logic                    hw_err,
    output logic                    upd_valid,
    output logic [ADDRESS_BITS-1:0] upd_addr
);
    // state | meaning
    // IDLE  | no hw request in progress
    // WAIT  | hw request queued behind AXI traffic, counting wait cycles
    // ACK   | hw access done; hw_ack, hw_rdata and hw_err presented
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam int                    IDX_W     = (REGISTERS_CNT > 1) ? $clog2(REGISTERS_CNT) : 1;
    localparam logic [ADDRESS_BITS:0] CNT_LIMIT = (ADDRESS_BITS + 1)'(REGISTERS_CNT);
    localparam logic [7:0]            WAIT_MAX  = 8'(MAX_WAIT);

    logic [31:0] regs_q [REGISTERS_CNT];
    logic [31:0] regs_d [REGISTERS_CNT];

    logic [1:0]              state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    dev_ready_q, dev_ready_d;
    logic [31:0]             latch_q, latch_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    hw_ack_q, hw_ack_d;
    logic                    hw_err_q, hw_err_d;
    logic [31:0]             hw_rdata_q, hw_rdata_d;
    logic                    upd_valid_q, upd_valid_d;
    logic [ADDRESS_BITS-1:0] upd_addr_q, upd_addr_d;

    logic             axi_busy;
    logic             hw_go;
    logic             w_ok, r_ok, h_ok;
    logic [IDX_W-1:0] w_idx, r_idx, h_idx;

    // Full-width compare: upper address bits must not alias onto valid registers.
    function automatic logic in_range(input logic [ADDRESS_BITS-1:0] addr);
        return {1'b0, addr} < CNT_LIMIT;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  stb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (stb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    assign axi_busy = bram_wen | bram_ren;
    assign w_ok     = in_range(bram_waddr);
    assign r_ok     = in_range(bram_raddr);
    assign h_ok     = in_range(hw_addr);
    assign w_idx    = bram_waddr[IDX_W-1:0];
    assign r_idx    = bram_raddr[IDX_W-1:0];
    assign h_idx    = hw_addr[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hw_go   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hw_req) begin
                    if (axi_busy) begin
                        state_d = ST_WAIT;
                        cnt_d   = 8'd1;
                    end else begin
                        hw_go   = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (!axi_busy) begin
                    hw_go   = 1'b1;
                    state_d = ST_ACK;
                    cnt_d   = '0;
                end else if (cnt_q != WAIT_MAX) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Throttle new bursts once the wait has saturated; release as soon as hw got its slot.
    always_comb begin
        dev_ready_d = dev_ready_q;
        if (hw_go) begin
            dev_ready_d = 1'b1;
        end else if (state_q == ST_WAIT && cnt_q == WAIT_MAX) begin
            dev_ready_d = 1'b0;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (bram_wen) begin
            if (w_ok) regs_d[w_idx] = merge_bytes(regs_q[w_idx], bram_wdata, bram_wstb);
        end else if (hw_go && hw_we && h_ok) begin
            regs_d[h_idx] = merge_bytes(regs_q[h_idx], hw_wdata, hw_wstb);
        end

        latch_d = latch_q;
        if (bram_ren && !bram_wen) latch_d = r_ok ? regs_q[r_idx] : 32'h0;
        rdata_d = bram_regen ? latch_q : rdata_q;

        upd_valid_d = bram_wen && w_ok;
        upd_addr_d  = upd_valid_d ? bram_waddr : upd_addr_q;

        hw_ack_d   = hw_go;
        hw_err_d   = hw_go && !h_ok;
        hw_rdata_d = hw_rdata_q;
        if (hw_go && !hw_we) hw_rdata_d = h_ok ? regs_q[h_idx] : 32'h0;
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dev_ready_q <= 1'b1;
            latch_q     <= '0;
            rdata_q     <= '0;
            hw_ack_q    <= 1'b0;
            hw_err_q    <= 1'b0;
            hw_rdata_q  <= '0;
            upd_valid_q <= 1'b0;
            upd_addr_q  <= '0;
            for (int i = 0; i < REGISTERS_CNT; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dev_ready_q <= dev_ready_d;
            latch_q     <= latch_d;
            rdata_q     <= rdata_d;
            hw_ack_q    <= hw_ack_d;
            hw_err_q    <= hw_err_d;
            hw_rdata_q  <= hw_rdata_d;
            upd_valid_q <= upd_valid_d;
            upd_addr_q  <= upd_addr_d;
            regs_q      <= regs_d;
        end
    end

    assign bram_rdata    = rdata_q;
    assign axi_dev_ready = dev_ready_q;
    assign hw_ack        = hw_ack_q;
    assign hw_err        = hw_err_q;
    assign hw_rdata      = hw_rdata_q;
    assign upd_valid     = upd_valid_q;
    assign upd_addr      = upd_addr_q;

endmodule

// File: tb/tb_axi_regs_arbiter.sv
// Bench for axi_regs_arbiter: AXI vector table, hand-written arbitration/reset
// sequences, then random traffic against a word-array reference model.
module tb_axi_regs_arbiter;
    localparam int NREG = 20;
    localparam int MAXW = 4;

    logic        aclk = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] bram_waddr = '0;
    logic [31:0] bram_wdata = '0;
    logic [3:0]  bram_wstb  = '0;
    logic        bram_wen   = 1'b0;
    logic [15:0] bram_raddr = '0;
    logic        bram_ren   = 1'b0;
    logic        bram_regen = 1'b0;
    logic [31:0] bram_rdata;
    logic        axi_dev_ready;
    logic        hw_req   = 1'b0;
    logic        hw_we    = 1'b0;
    logic [15:0] hw_addr  = '0;
    logic [31:0] hw_wdata = '0;
    logic [3:0]  hw_wstb  = '0;
    logic        hw_ack;
    logic [31:0] hw_rdata;
    logic        hw_err;
    logic        upd_valid;
    logic [15:0] upd_addr;

    int errors = 0;
    int checks = 0;

    axi_regs_arbiter #(.REGISTERS_CNT(NREG), .ADDRESS_BITS(16), .MAX_WAIT(MAXW)) dut (
        .aclk(aclk), .rst(rst),
        .bram_waddr(bram_waddr), .bram_wdata(bram_wdata), .bram_wstb(bram_wstb), .bram_wen(bram_wen),
        .bram_raddr(bram_raddr), .bram_ren(bram_ren), .bram_regen(bram_regen), .bram_rdata(bram_rdata),
        .axi_dev_ready(axi_dev_ready),
        .hw_req(hw_req), .hw_we(hw_we), .hw_addr(hw_addr), .hw_wdata(hw_wdata), .hw_wstb(hw_wstb),
        .hw_ack(hw_ack), .hw_rdata(hw_rdata), .hw_err(hw_err),
        .upd_valid(upd_valid), .upd_addr(upd_addr)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        wen;
        logic [15:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstb;
        logic        ren;
        logic [15:0] raddr;
        logic        regen;
        logic        exp_upd;
        logic [15:0] exp_upd_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_idle();
        bram_wen = 1'b0; bram_ren = 1'b0; bram_regen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        axi_idle();
        hw_req = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // AXI read of one address through the two-stage pipeline; returns bram_rdata.
    task automatic axi_read(input logic [15:0] a, output logic [31:0] d);
        axi_idle(); bram_ren = 1'b1; bram_raddr = a;
        step();
        axi_idle(); bram_regen = 1'b1;
        step();
        axi_idle();
        d = bram_rdata;
    endtask

    logic [31:0] m_mem [NREG];
    logic [31:0] m_latch, m_rdata, m_hw_rdata, rd;
    logic [15:0] m_upd_addr;
    logic        e_ack, e_err, e_upd, e_ready, serve, served_prev, busy;
    int          s_cyc, burst_left, k;

    initial begin
        vecs[0]  = '{1'b1, 16'd3,     32'hA5A5_1234, 4'hF, 1'b0, 16'd0,  1'b0, 1'b1, 16'd3, 32'h0};
        vecs[1]  = '{1'b1, 16'd7,     32'h1111_2222, 4'hF, 1'b0, 16'd0,  1'b0, 1'b1, 16'd7, 32'h0};
        vecs[2]  = '{1'b1, 16'd7,     32'hDEAD_0000, 4'hC, 1'b0, 16'd0,  1'b0, 1'b1, 16'd7, 32'h0};
        vecs[3]  = '{1'b1, 16'd25,    32'hFFFF_FFFF, 4'hF, 1'b0, 16'd0,  1'b0, 1'b0, 16'd7, 32'h0};
        vecs[4]  = '{1'b0, 16'd0,     32'h0,         4'h0, 1'b1, 16'd3,  1'b0, 1'b0, 16'd7, 32'h0};
        vecs[5]  = '{1'b0, 16'd0,     32'h0,         4'h0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd7, 32'hA5A5_1234};
        vecs[6]  = '{1'b0, 16'd0,     32'h0,         4'h0, 1'b1, 16'd7,  1'b0, 1'b0, 16'd7, 32'hA5A5_1234};
        vecs[7]  = '{1'b0, 16'd0,     32'h0,         4'h0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd7, 32'hDEAD_2222};
        vecs[8]  = '{1'b0, 16'd0,     32'h0,         4'h0, 1'b1, 16'd25, 1'b0, 1'b0, 16'd7, 32'hDEAD_2222};
        vecs[9]  = '{1'b0, 16'd0,     32'h0,         4'h0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd7, 32'h0};
        vecs[10] = '{1'b1, 16'h0103,  32'hFFFF_FFFF, 4'hF, 1'b0, 16'd0,  1'b0, 1'b0, 16'd7, 32'h0};
        vecs[11] = '{1'b0, 16'd0,     32'h0,         4'h0, 1'b1, 16'd3,  1'b1, 1'b0, 16'd7, 32'h0};
        vecs[12] = '{1'b0, 16'd0,     32'h0,         4'h0, 1'b0, 16'd0,  1'b0, 1'b0, 16'd7, 32'h0};
        vecs[13] = '{1'b0, 16'd0,     32'h0,         4'h0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd7, 32'hA5A5_1234};
        vecs[14] = '{1'b1, 16'd3,     32'h0000_0001, 4'hF, 1'b1, 16'd7,  1'b0, 1'b1, 16'd3, 32'hA5A5_1234};
        vecs[15] = '{1'b0, 16'd0,     32'h0,         4'h0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd3, 32'hA5A5_1234};
        vecs[16] = '{1'b0, 16'd0,     32'h0,         4'h0, 1'b1, 16'd3,  1'b0, 1'b0, 16'd3, 32'hA5A5_1234};
        vecs[17] = '{1'b0, 16'd0,     32'h0,         4'h0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd3, 32'h0000_0001};

        do_reset();
        chk("reset bram_rdata", bram_rdata, 32'h0);
        chk("reset dev_ready", {31'h0, axi_dev_ready}, 32'h1);
        chk("reset hw_ack", {31'h0, hw_ack}, 32'h0);
        chk("reset hw_err", {31'h0, hw_err}, 32'h0);
        chk("reset hw_rdata", hw_rdata, 32'h0);
        chk("reset upd_valid", {31'h0, upd_valid}, 32'h0);
        chk("reset upd_addr", {16'h0, upd_addr}, 32'h0);

        // AXI path vector table
        for (int i = 0; i < 18; i++) begin
            bram_wen = vecs[i].wen; bram_waddr = vecs[i].waddr; bram_wdata = vecs[i].wdata;
            bram_wstb = vecs[i].wstb; bram_ren = vecs[i].ren; bram_raddr = vecs[i].raddr;
            bram_regen = vecs[i].regen;
            step();
            chk($sformatf("vec%0d upd_valid", i), {31'h0, upd_valid}, {31'h0, vecs[i].exp_upd});
            chk($sformatf("vec%0d upd_addr", i), {16'h0, upd_addr}, {16'h0, vecs[i].exp_upd_addr});
            chk($sformatf("vec%0d bram_rdata", i), bram_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d dev_ready", i), {31'h0, axi_dev_ready}, 32'h1);
        end
        axi_idle();

        // hw write then read of addr 5 with AXI idle
        hw_req = 1'b1; hw_we = 1'b1; hw_addr = 16'd5; hw_wdata = 32'h0000_00FF; hw_wstb = 4'b0001;
        step();
        chk("hw wr5 ack", {31'h0, hw_ack}, 32'h1);
        chk("hw wr5 err", {31'h0, hw_err}, 32'h0);
        hw_req = 1'b0;
        step();
        chk("hw wr5 ack pulse", {31'h0, hw_ack}, 32'h0);
        hw_req = 1'b1; hw_we = 1'b0; hw_addr = 16'd5;
        step();
        chk("hw rd5 ack", {31'h0, hw_ack}, 32'h1);
        chk("hw rd5 data", hw_rdata, 32'h0000_00FF);
        chk("hw rd5 err", {31'h0, hw_err}, 32'h0);
        hw_req = 1'b0;
        step();

        // hw read of addr 10 arriving during a 16-beat AXI write burst
        for (int b = 0; b < 16; b++) begin
            bram_wen = 1'b1; bram_waddr = 16'(b); bram_wdata = 32'h1000_0000 + 32'(b); bram_wstb = 4'hF;
            if (b == 2) begin hw_req = 1'b1; hw_we = 1'b0; hw_addr = 16'd10; end
            step();
            if (b >= 2) chk($sformatf("starve ready v%0d", b - 1), {31'h0, axi_dev_ready},
                            (b - 1 >= 5) ? 32'h0 : 32'h1);
            else        chk($sformatf("starve ready pre%0d", b), {31'h0, axi_dev_ready}, 32'h1);
            chk($sformatf("starve no ack b%0d", b), {31'h0, hw_ack}, 32'h0);
        end
        axi_idle();
        step();
        chk("starve ack", {31'h0, hw_ack}, 32'h1);
        chk("starve rdata", hw_rdata, 32'h1000_000A);
        chk("starve ready back", {31'h0, axi_dev_ready}, 32'h1);
        hw_req = 1'b0;
        step();
        chk("starve ack pulse", {31'h0, hw_ack}, 32'h0);

        // out-of-range hw write
        hw_req = 1'b1; hw_we = 1'b1; hw_addr = 16'd25; hw_wdata = 32'hCAFE_BABE; hw_wstb = 4'hF;
        step();
        chk("oor ack", {31'h0, hw_ack}, 32'h1);
        chk("oor err", {31'h0, hw_err}, 32'h1);
        hw_req = 1'b0;
        step();
        axi_read(16'd25, rd);
        chk("oor axi read", rd, 32'h0);
        axi_read(16'd5, rd);
        chk("oor reg5 unchanged", rd, 32'h1000_0005);

        // reset while a hw request sits in WAIT
        for (int b = 0; b < 6; b++) begin
            bram_wen = 1'b1; bram_waddr = 16'd3; bram_wdata = 32'h3333_3333; bram_wstb = 4'hF;
            if (b == 0) begin hw_req = 1'b1; hw_we = 1'b0; hw_addr = 16'd3; end
            step();
        end
        chk("wait ready low", {31'h0, axi_dev_ready}, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rst ready", {31'h0, axi_dev_ready}, 32'h1);
        chk("rst ack", {31'h0, hw_ack}, 32'h0);
        chk("rst upd_valid", {31'h0, upd_valid}, 32'h0);
        axi_idle();
        step();
        step();
        chk("rst held no ack", {31'h0, hw_ack}, 32'h0);
        rst = 1'b0;
        step();
        chk("post rst ack", {31'h0, hw_ack}, 32'h1);
        chk("post rst rdata", hw_rdata, 32'h0);
        hw_req = 1'b0;
        step();
        axi_read(16'd7, rd);
        chk("post rst reg7", rd, 32'h0);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < NREG; i++) m_mem[i] = '0;
        m_latch = '0; m_rdata = '0; m_hw_rdata = '0; m_upd_addr = '0;
        served_prev = 1'b0; s_cyc = 0; burst_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (served_prev) begin
                hw_req = 1'b0;
            end else if (!hw_req && $urandom_range(0, 3) == 0) begin
                hw_req = 1'b1; hw_we = 1'($urandom_range(0, 1)); hw_addr = 16'($urandom_range(0, 23));
                hw_wdata = $urandom; hw_wstb = 4'($urandom_range(0, 15)); s_cyc = c;
            end
            if (burst_left == 0 && $urandom_range(0, 19) == 0) burst_left = $urandom_range(4, 12);
            if (burst_left > 0) begin
                k = $urandom_range(0, 5);
                burst_left--;
            end else begin
                k = $urandom_range(0, 9);
            end
            bram_wen = (k < 4); bram_ren = (k == 4 || k == 5);
            bram_waddr = 16'($urandom_range(0, 23)); bram_raddr = 16'($urandom_range(0, 23));
            bram_wdata = $urandom; bram_wstb = 4'($urandom_range(0, 15));
            bram_regen = 1'($urandom_range(0, 1));

            busy  = bram_wen | bram_ren;
            serve = hw_req && !busy;
            e_ready = !(hw_req && !serve && (c - s_cyc) >= MAXW);
            e_ack = serve;
            e_err = serve && (hw_addr >= NREG);
            if (serve) begin
                if (hw_addr < NREG) begin
                    if (hw_we) m_mem[hw_addr] = merge(m_mem[hw_addr], hw_wdata, hw_wstb);
                    else       m_hw_rdata = m_mem[hw_addr];
                end else if (!hw_we) begin
                    m_hw_rdata = 32'h0;
                end
            end
            if (bram_regen) m_rdata = m_latch;
            if (bram_ren) m_latch = (bram_raddr < NREG) ? m_mem[bram_raddr] : 32'h0;
            e_upd = bram_wen && (bram_waddr < NREG);
            if (e_upd) begin
                m_mem[bram_waddr] = merge(m_mem[bram_waddr], bram_wdata, bram_wstb);
                m_upd_addr = bram_waddr;
            end
            served_prev = serve;

            step();
            chk("rnd ready", {31'h0, axi_dev_ready}, {31'h0, e_ready});
            chk("rnd ack", {31'h0, hw_ack}, {31'h0, e_ack});
            chk("rnd err", {31'h0, hw_err}, {31'h0, e_err});
            chk("rnd hw_rdata", hw_rdata, m_hw_rdata);
            chk("rnd bram_rdata", bram_rdata, m_rdata);
            chk("rnd upd_valid", {31'h0, upd_valid}, {31'h0, e_upd});
            chk("rnd upd_addr", {16'h0, upd_addr}, {16'h0, m_upd_addr});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
